// File: rtl/yacht_pkg.sv
// Shared definitions for the Yacht Dice datapath: die geometry, roller states,
// LFSR taps and the byte-to-face mapping.
package yacht_pkg;

  localparam int          NUM_DICE  = 5;
  localparam int          DIE_W     = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ANIM,
    ST_SETTLE,
    ST_DONE
  } roll_state_e;

  // Low byte modulo 6 lands in 0..5, so the 3-bit truncation of (r + 1) is exact.
  function automatic logic [DIE_W-1:0] face(input logic [15:0] x);
    logic [7:0] r;
    r = (x[7:0] % 8'd6) + 8'd1;
    return r[DIE_W-1:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting, taps from yacht_pkg),
// loaded with SEED on synchronous reset.
module lfsr16
  import yacht_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/dice_roller.sv
// Five-die roll engine feeding the Yacht game FSM; a die value of 0 means "not rolled".
// Define DICE_ANIM_EN to include the display animation phase before the dice settle.
module dice_roller
  import yacht_pkg::*;
#(
  parameter int          ANIM_FRAMES = 12,
  parameter int          FRAME_DIV   = 2_500_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        roll_trigger,
  input  logic        turn_start,
  input  logic [4:0]  hold_sw,
  output logic [2:0]  d1,
  output logic [2:0]  d2,
  output logic [2:0]  d3,
  output logic [2:0]  d4,
  output logic [2:0]  d5,
  output logic [14:0] disp_dice,
  output logic        rolling,
  output logic        roll_done
);

  typedef logic [NUM_DICE-1:0][DIE_W-1:0] dice_t;

  roll_state_e         state_q, state_d;
  logic [NUM_DICE-1:0] mask_q, mask_d;
  dice_t               dice_q, dice_d;
  dice_t               disp_q, disp_d;
  logic [2:0]          idx_q, idx_d;
  logic                rolling_q, rolling_d;
  logic                done_q, done_d;
  logic [15:0]         lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

`ifdef DICE_ANIM_EN
  localparam int               CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int               FRM_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(ANIM_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FRM_W-1:0] frame_idx_q, frame_idx_d;
  dice_t            anim_q, anim_d;
`else
  logic [31:0] unused_anim_cfg;
  assign unused_anim_cfg = 32'(ANIM_FRAMES) ^ 32'(FRAME_DIV);
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    dice_d    = dice_q;
    idx_d     = idx_q;
    rolling_d = rolling_q;
    done_d    = 1'b0;
`ifdef DICE_ANIM_EN
    frame_cnt_d = frame_cnt_q;
    frame_idx_d = frame_idx_q;
    anim_d      = anim_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (roll_trigger) begin
          // An unrolled die is always rolled, even when its hold switch is on.
          for (int i = 0; i < NUM_DICE; i++) begin
            mask_d[i] = !hold_sw[i] || (dice_q[i] == '0);
            if (mask_d[i]) begin
              dice_d[i] = '0;
            end
          end
          idx_d     = '0;
          rolling_d = 1'b1;
`ifdef DICE_ANIM_EN
          frame_cnt_d = '0;
          frame_idx_d = '0;
          anim_d      = '0;
          state_d     = ST_ANIM;
`else
          state_d     = ST_SETTLE;
`endif
        end
      end
`ifdef DICE_ANIM_EN
      ST_ANIM: begin
        if (frame_cnt_q == CNT_LAST) begin
          frame_cnt_d = '0;
          for (int i = 0; i < NUM_DICE; i++) begin
            if (mask_q[i]) begin
              anim_d[i] = face(lfsr >> (2 * i));
            end
          end
          if (frame_idx_q == FRM_LAST) begin
            state_d = ST_SETTLE;
          end else begin
            frame_idx_d = frame_idx_q + 1'b1;
          end
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
`endif
      ST_SETTLE: begin
        for (int i = 0; i < NUM_DICE; i++) begin
          if ((idx_q == 3'(i)) && mask_q[i]) begin
            dice_d[i] = face(lfsr);
          end
        end
        if (idx_q == 3'(NUM_DICE - 1)) begin
          state_d   = ST_DONE;
          rolling_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new turn overrides whatever the roller was doing, including a same-cycle trigger.
    if (turn_start) begin
      state_d   = ST_IDLE;
      mask_d    = '0;
      dice_d    = '0;
      idx_d     = '0;
      rolling_d = 1'b0;
      done_d    = 1'b0;
`ifdef DICE_ANIM_EN
      anim_d    = '0;
`endif
    end

    for (int i = 0; i < NUM_DICE; i++) begin
      disp_d[i] = dice_d[i];
`ifdef DICE_ANIM_EN
      if ((state_d == ST_ANIM) && mask_d[i]) begin
        disp_d[i] = anim_d[i];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      dice_q    <= '0;
      disp_q    <= '0;
      idx_q     <= '0;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef DICE_ANIM_EN
      frame_cnt_q <= '0;
      frame_idx_q <= '0;
      anim_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      dice_q    <= dice_d;
      disp_q    <= disp_d;
      idx_q     <= idx_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
`ifdef DICE_ANIM_EN
      frame_cnt_q <= frame_cnt_d;
      frame_idx_q <= frame_idx_d;
      anim_q      <= anim_d;
`endif
    end
  end

  assign d1        = dice_q[0];
  assign d2        = dice_q[1];
  assign d3        = dice_q[2];
  assign d4        = dice_q[3];
  assign d5        = dice_q[4];
  assign disp_dice = disp_q;
  assign rolling   = rolling_q;
  assign roll_done = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller; follows DICE_ANIM_EN to pick the animation length.
// Expected dice come from an independent LFSR/face model run alongside the DUT.
module tb_dice_roller;

  localparam int          AF   = 2;
  localparam int          FD   = 3;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef DICE_ANIM_EN
  localparam int N = AF * FD;
`else
  localparam int N = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        roll_trigger = 1'b0;
  logic        turn_start = 1'b0;
  logic [4:0]  hold_sw = 5'b0;
  logic [2:0]  d1, d2, d3, d4, d5;
  logic [14:0] disp_dice;
  logic        rolling, roll_done;
  logic [14:0] dice_now;

  assign dice_now = {d5, d4, d3, d2, d1};

  dice_roller #(
    .ANIM_FRAMES (AF),
    .FRAME_DIV   (FD),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .roll_trigger (roll_trigger),
    .turn_start   (turn_start),
    .hold_sw      (hold_sw),
    .d1           (d1),
    .d2           (d2),
    .d3           (d3),
    .d4           (d4),
    .d5           (d5),
    .disp_dice    (disp_dice),
    .rolling      (rolling),
    .roll_done    (roll_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    logic [14:0] dice;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr = SEED;
  logic [14:0] exp_d = '0;
  logic [5:0]  seen [5] = '{default: 6'b0};

  function automatic logic [15:0] lfsrStep(input logic [15:0] s, input int n);
    logic [15:0] r;
    r = s;
    for (int k = 0; k < n; k++) begin
      if (r[0]) r = (r >> 1) ^ 16'hB400;
      else      r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [2:0] faceOf(input logic [15:0] x);
    int v;
    v = (int'(x[7:0]) % 6) + 1;
    return v[2:0];
  endfunction

  // Reference LFSR tracks the DUT's generator cycle for cycle from reset.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= reset ? SEED : lfsrStep(m_lfsr, 1);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every roll_done must match the oldest outstanding expected roll.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [2:0] v;
    if (!reset && roll_done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_roll_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("roll_done_cycle", cyc, e.done_cyc);
        checkOutput("dice_at_done", dice_now, e.dice);
        for (int i = 0; i < 5; i++) begin
          v = dice_now[3*i +: 3];
          if (v >= 3'd1 && v <= 3'd6) seen[i][v - 3'd1] = 1'b1;
        end
      end
    end
  end

  // Issues one roll at the current negedge and checks every cycle through the return to IDLE.
  // abort_kind 1 = turn_start at cycle T+abort_at, 2 = reset at T+abort_at.
  task automatic applyStimulus(input logic [4:0] hold, input bit extra, input int abort_kind,
                               input int abort_at);
    logic [15:0] l0, la;
    logic [4:0]  mask;
    logic [14:0] pred, prev, expv, expdisp;
    int          k;
    l0   = m_lfsr;
    prev = exp_d;
    for (int i = 0; i < 5; i++) begin
      mask[i] = !hold[i] || (prev[3*i +: 3] == 3'd0);
      pred[3*i +: 3] = mask[i] ? faceOf(lfsrStep(l0, N + 1 + i)) : prev[3*i +: 3];
    end
    sb.push_back('{done_cyc: cyc + N + 6, dice: pred});
    hold_sw      = hold;
    roll_trigger = 1'b1;
    for (int j = 1; j <= N + 7; j++) begin
      @(negedge clk);
      roll_trigger = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (mask[i]) expv[3*i +: 3] = (j >= N + 2 + i) ? pred[3*i +: 3] : 3'd0;
        else         expv[3*i +: 3] = prev[3*i +: 3];
      end
      expdisp = expv;
      if (j <= N) begin
        k  = (j - 1) / FD;
        la = lfsrStep(l0, k * FD);
        for (int i = 0; i < 5; i++) begin
          if (mask[i]) expdisp[3*i +: 3] = (k == 0) ? 3'd0 : faceOf(la >> (2 * i));
        end
      end
      checkOutput("rolling", 32'(rolling), 32'(j <= N + 5));
      checkOutput("dice", dice_now, expv);
      checkOutput("disp_dice", disp_dice, expdisp);
      if (abort_kind != 0 && j == abort_at) begin
        if (abort_kind == 1) turn_start = 1'b1;
        else                 reset = 1'b1;
        @(negedge clk);
        turn_start = 1'b0;
        reset      = 1'b0;
        checkOutput(abort_kind == 1 ? "turn_start_clear" : "reset_clear",
                    {rolling, roll_done, disp_dice, dice_now}, 32'd0);
        void'(sb.pop_back());
        exp_d   = '0;
        hold_sw = 5'b0;
        return;
      end
      if (j == 2) hold_sw = ~hold;
      if (extra && (j == 3 || j == N + 6)) roll_trigger = 1'b1;
    end
    exp_d = pred;
  endtask

  task automatic idleCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle_rolling", 32'(rolling), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_state", {rolling, roll_done, disp_dice, dice_now}, 32'd0);
    end

    $display("[TB] first roll, nothing held");
    applyStimulus(5'b00000, 1'b0, 0, 0);
    idleCheck(2);
    $display("[TB] partial hold of d1 and d3");
    applyStimulus(5'b00101, 1'b0, 0, 0);
    $display("[TB] extra triggers mid-roll and during DONE");
    applyStimulus(5'b11010, 1'b1, 0, 0);
    idleCheck(N + 8);
    $display("[TB] turn_start mid-roll, then full hold after clear");
    applyStimulus(5'b00000, 1'b0, 1, 4);
    idleCheck(N + 8);
    applyStimulus(5'b11111, 1'b0, 0, 0);
    $display("[TB] reset mid-roll");
    applyStimulus(5'b01001, 1'b0, 2, 3);
    idleCheck(3);
    applyStimulus(5'b11111, 1'b0, 0, 0);

    $display("[TB] bulk rolls at random gaps");
    for (int r = 0; r < 1000; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus(5'($urandom_range(0, 31)), 1'b0, 0, 0);
    end
    idleCheck(N + 8);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("faces_seen_d%0d", i + 1), 32'(seen[i]), 32'h3F);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
